// File: rtl/iter_muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op codes, FSM state encoding, captured-op context and small op decoders.
package iter_muldiv_unit_pkg;

   localparam int unsigned MD_OP_WIDTH = 3;

   typedef enum logic [MD_OP_WIDTH-1:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MADD  = 3'd4,
      MD_MADDU = 3'd5,
      MD_MSUB  = 3'd6,
      MD_MSUBU = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2
   } md_state_e;

   // Operation context captured at the accept edge
   typedef struct packed {
      md_op_e op;
      logic   sign1;
      logic   sign2;
   } md_ctx_t;

   // Even op codes are the signed variants
   function automatic logic md_is_signed(input md_op_e op);
      return ~op[0];
   endfunction

   function automatic logic md_is_div(input md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/iter_muldiv_unit_if.sv
// Request/result bundle of the multiply/divide unit.
// master: issues ops and direct HI/LO writes; slave: the unit.
//   i_valid/o_ready start handshake, i_op/i_opr1/i_opr2 operands,
//   i_cancel abort, i_hi_we/i_lo_we/i_wdata direct writes,
//   o_busy/o_done/o_div_by_zero status, o_hi/o_lo architectural registers.
interface iter_muldiv_unit_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   import iter_muldiv_unit_pkg::*;

   logic                   i_valid;
   logic                   o_ready;
   logic [MD_OP_WIDTH-1:0] i_op;
   logic [DATA_WIDTH-1:0]  i_opr1;
   logic [DATA_WIDTH-1:0]  i_opr2;
   logic                   i_cancel;
   logic                   i_hi_we;
   logic                   i_lo_we;
   logic [DATA_WIDTH-1:0]  i_wdata;
   logic                   o_busy;
   logic                   o_done;
   logic                   o_div_by_zero;
   logic [DATA_WIDTH-1:0]  o_hi;
   logic [DATA_WIDTH-1:0]  o_lo;

   modport master (
      output i_valid, i_op, i_opr1, i_opr2, i_cancel, i_hi_we, i_lo_we, i_wdata,
      input  o_ready, o_busy, o_done, o_div_by_zero, o_hi, o_lo
   );

   modport slave (
      input  i_valid, i_op, i_opr1, i_opr2, i_cancel, i_hi_we, i_lo_we, i_wdata,
      output o_ready, o_busy, o_done, o_div_by_zero, o_hi, o_lo
   );

endinterface

// File: rtl/iter_muldiv_unit_cond_negate.sv
// Conditional two's-complement negation (cond_negate).
//   data     : value in
//   neg      : negate when high
//   result_c : data or -data (mod 2^WIDTH), combinational
module iter_muldiv_unit_cond_negate #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] data,
   input  logic             neg,
   output logic [WIDTH-1:0] result_c
);

   assign result_c = neg ? (~data + WIDTH'(1)) : data;

endmodule

// File: rtl/iter_muldiv_unit.sv
// Radix-2 iterative multiply/divide unit with HI/LO registers.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : start handshake, operands, cancel, direct HI/LO writes,
//                  busy/done/div-by-zero status and the HI/LO outputs.
// Magnitudes are processed unsigned for W cycles; a single FIX cycle restores
// signs, applies MADD/MSUB accumulation and commits HI/LO.
module iter_muldiv_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
   input logic               i_clk,
   input logic               i_rst,
   iter_muldiv_unit_if.slave bus
);
   import iter_muldiv_unit_pkg::*;

   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned W2 = 2 * DATA_WIDTH;

   md_state_e            state_q, state_d;
   md_ctx_t              ctx_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [W-1:0]         b_q, hi_q, lo_q;
   logic [W2-1:0]        work_q;
   logic                 done_q, dbz_q;

   logic          ready_c, busy_c, accept_c, abort_c, commit_c;
   md_op_e        op_in_c;
   logic          sign1_c, sign2_c;
   logic [W-1:0]  mag1_c, mag2_c;
   logic          is_div_c, b_zero_c;
   logic [W:0]    mul_sum_c, div_shift_c;
   logic          div_ge_c;
   logic [W-1:0]  div_rem_c;
   logic [W2-1:0] work_d_c;
   logic [W2-1:0] prod_c, res_c;
   logic [W-1:0]  quot_c, rem_c;

   // Operand magnitudes; unsigned ops pass through untouched
   assign op_in_c = md_op_e'(bus.i_op);
   assign sign1_c = md_is_signed(op_in_c) & bus.i_opr1[W-1];
   assign sign2_c = md_is_signed(op_in_c) & bus.i_opr2[W-1];

   iter_muldiv_unit_cond_negate #(.WIDTH(W)) u_mag1 (
      .data(bus.i_opr1), .neg(sign1_c), .result_c(mag1_c));
   iter_muldiv_unit_cond_negate #(.WIDTH(W)) u_mag2 (
      .data(bus.i_opr2), .neg(sign2_c), .result_c(mag2_c));

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= MD_IDLE;
      else       state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         MD_IDLE: if (accept_c) state_d = MD_CALC;
         MD_CALC: begin
            if (abort_c)            state_d = MD_IDLE;
            else if (cnt_q == '0)   state_d = MD_FIX;
         end
         MD_FIX:  state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   // Handshake/control outputs; a direct write while busy aborts like cancel
   always_comb begin
      busy_c   = 1'b0;
      ready_c  = 1'b0;
      accept_c = 1'b0;
      abort_c  = 1'b0;
      commit_c = 1'b0;
      busy_c   = (state_q != MD_IDLE);
      ready_c  = ~busy_c & ~bus.i_hi_we & ~bus.i_lo_we;
      accept_c = bus.i_valid & ready_c;
      abort_c  = busy_c & (bus.i_cancel | bus.i_hi_we | bus.i_lo_we);
      commit_c = (state_q == MD_FIX) & ~abort_c;
   end

   assign bus.o_ready       = ready_c;
   assign bus.o_busy        = busy_c;
   assign bus.o_done        = done_q;
   assign bus.o_div_by_zero = dbz_q;
   assign bus.o_hi          = hi_q;
   assign bus.o_lo          = lo_q;

   assign is_div_c = md_is_div(ctx_q.op);
   assign b_zero_c = (b_q == '0);

   // One iteration: shift-add for multiply, restoring step for divide.
   // Divide keeps {remainder, quotient/dividend} in work_q.
   always_comb begin
      mul_sum_c   = {1'b0, work_q[W2-1:W]} + {1'b0, (work_q[0] ? b_q : {W{1'b0}})};
      div_shift_c = {work_q[W2-1:W], work_q[W-1]};
      div_ge_c    = (div_shift_c >= {1'b0, b_q});
      div_rem_c   = div_ge_c ? (div_shift_c[W-1:0] - b_q) : div_shift_c[W-1:0];
      if (is_div_c) work_d_c = {div_rem_c, work_q[W-2:0], div_ge_c};
      else          work_d_c = {mul_sum_c, work_q[W-1:1]};
   end

   // Iteration registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ctx_q  <= '0;
         cnt_q  <= '0;
         b_q    <= '0;
         work_q <= '0;
      end else if (accept_c) begin
         ctx_q  <= '{op: op_in_c, sign1: sign1_c, sign2: sign2_c};
         cnt_q  <= CNT_WIDTH'(W - 1);
         b_q    <= mag2_c;
         work_q <= {{W{1'b0}}, mag1_c};
      end else if (state_q == MD_CALC) begin
         cnt_q  <= cnt_q - CNT_WIDTH'(1);
         work_q <= work_d_c;
      end
   end

   // Sign correction: remainder follows the dividend's sign
   iter_muldiv_unit_cond_negate #(.WIDTH(W2)) u_prod (
      .data(work_q), .neg(ctx_q.sign1 ^ ctx_q.sign2), .result_c(prod_c));
   iter_muldiv_unit_cond_negate #(.WIDTH(W)) u_quot (
      .data(work_q[W-1:0]), .neg(ctx_q.sign1 ^ ctx_q.sign2), .result_c(quot_c));
   iter_muldiv_unit_cond_negate #(.WIDTH(W)) u_rem (
      .data(work_q[W2-1:W]), .neg(ctx_q.sign1), .result_c(rem_c));

   // Result selection; with a zero divisor the remainder is the raw dividend
   always_comb begin
      res_c = prod_c;
      case (ctx_q.op)
         MD_MADD, MD_MADDU: res_c = {hi_q, lo_q} + prod_c;
         MD_MSUB, MD_MSUBU: res_c = {hi_q, lo_q} - prod_c;
         MD_DIV, MD_DIVU:   res_c = {rem_c, (b_zero_c ? {W{1'b1}} : quot_c)};
         default:           res_c = prod_c;
      endcase
   end

   // HI/LO and status; direct writes always land, commits only when not aborted
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         done_q <= commit_c;
         dbz_q  <= commit_c & is_div_c & b_zero_c;
         if (commit_c)    {hi_q, lo_q} <= res_c;
         if (bus.i_hi_we) hi_q <= bus.i_wdata;
         if (bus.i_lo_we) lo_q <= bus.i_wdata;
      end
   end

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Scoreboard bench for iter_muldiv_unit (W=32): expected HI/LO/flag are
// predicted from a behavioural model when an op is issued and compared when
// o_done pulses, together with the latency.
module tb_iter_muldiv_unit;
   import iter_muldiv_unit_pkg::*;

   localparam int unsigned W   = 32;
   localparam int          LAT = W + 2;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          total = 0;
   int          bad = 0;
   exp_t        sb_q[$];
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   iter_muldiv_unit_if #(.DATA_WIDTH(W)) bus ();

   iter_muldiv_unit #(.DATA_WIDTH(W)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Behavioural reference using the current model HI/LO for accumulation
   function automatic exp_t predict(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] sp, up, acc;
      sp  = 64'(longint'($signed(a)) * longint'($signed(b)));
      up  = {32'd0, a} * {32'd0, b};
      acc = {m_hi, m_lo};
      e.dbz = 1'b0;
      {e.hi, e.lo} = sp;
      case (md_op_e'(op))
         MD_MULTU: {e.hi, e.lo} = up;
         MD_MADD:  {e.hi, e.lo} = acc + sp;
         MD_MADDU: {e.hi, e.lo} = acc + up;
         MD_MSUB:  {e.hi, e.lo} = acc - sp;
         MD_MSUBU: {e.hi, e.lo} = acc - up;
         MD_DIV: begin
            if (b == 32'd0) begin
               e.lo = '1; e.hi = a; e.dbz = 1'b1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               e.lo = a; e.hi = '0;
            end else begin
               e.lo = 32'($signed(a) / $signed(b));
               e.hi = 32'($signed(a) % $signed(b));
            end
         end
         MD_DIVU: begin
            if (b == 32'd0) begin
               e.lo = '1; e.hi = a; e.dbz = 1'b1;
            end else begin
               e.lo = a / b;
               e.hi = a % b;
            end
         end
         default: ;
      endcase
      return e;
   endfunction

   // Called #1 after a posedge; returns #1 after the accept edge
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit expect_done);
      exp_t e;
      bus.i_valid = 1'b1;
      bus.i_op    = op;
      bus.i_opr1  = a;
      bus.i_opr2  = b;
      #1;
      check("ready_at_issue", 64'(bus.o_ready), 64'd1);
      if (expect_done) begin
         e = predict(op, a, b);
         sb_q.push_back(e);
         m_hi = e.hi;
         m_lo = e.lo;
      end
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
   endtask

   // Cycle 1 is the cycle starting at the accept edge; done must be in cycle LAT
   task automatic wait_done();
      exp_t e;
      int   cyc = 1;
      while (!bus.o_done && cyc <= LAT + 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (!bus.o_done) begin
         check("done_seen", 64'(bus.o_done), 64'd1);
         return;
      end
      if (sb_q.size() == 0) begin
         check("done_expected", 64'(bus.o_done), 64'd0);
         return;
      end
      e = sb_q.pop_front();
      check("hi", 64'(bus.o_hi), 64'(e.hi));
      check("lo", 64'(bus.o_lo), 64'(e.lo));
      check("dbz", 64'(bus.o_div_by_zero), 64'(e.dbz));
      check("latency", 64'(cyc), 64'(LAT));
   endtask

   task automatic dwrite(input logic hwe, input logic lwe, input logic [31:0] d);
      bus.i_hi_we = hwe;
      bus.i_lo_we = lwe;
      bus.i_wdata = d;
      @(posedge clk); #1;
      bus.i_hi_we = 1'b0;
      bus.i_lo_we = 1'b0;
      if (hwe) m_hi = d;
      if (lwe) m_lo = d;
   endtask

   task automatic expect_no_done(input string tag, input int cycles);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (bus.o_done) seen++;
      end
      check(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [2:0]  rop;

      bus.i_valid = 1'b0; bus.i_op = '0; bus.i_opr1 = '0; bus.i_opr2 = '0;
      bus.i_cancel = 1'b0; bus.i_hi_we = 1'b0; bus.i_lo_we = 1'b0; bus.i_wdata = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_hi", 64'(bus.o_hi), 64'd0);
      check("rst_lo", 64'(bus.o_lo), 64'd0);
      check("rst_done", 64'(bus.o_done), 64'd0);
      check("rst_busy", 64'(bus.o_busy), 64'd0);
      check("rst_ready", 64'(bus.o_ready), 64'd1);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Multiply / divide corner cases, all issued back-to-back in done cycles
      issue(3'(MD_MULT),  32'hFFFF_FFFF, 32'd2, 1'b1); wait_done();
      issue(3'(MD_MULTU), 32'hFFFF_FFFF, 32'd2, 1'b1); wait_done();
      issue(3'(MD_DIV),   32'hFFFF_FFF9, 32'd2, 1'b1); wait_done();
      issue(3'(MD_DIVU),  32'd7,         32'd2, 1'b1); wait_done();
      issue(3'(MD_DIV),   32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done();
      issue(3'(MD_DIV),   32'd5,         32'd0, 1'b1); wait_done();
      @(posedge clk); #1;
      check("done_one_cycle", 64'(bus.o_done), 64'd0);
      check("dbz_clears", 64'(bus.o_div_by_zero), 64'd0);

      // Direct writes then accumulate
      dwrite(1'b1, 1'b0, 32'd0);
      dwrite(1'b0, 1'b1, 32'd10);
      check("dw_hi", 64'(bus.o_hi), 64'd0);
      check("dw_lo", 64'(bus.o_lo), 64'd10);
      issue(3'(MD_MADD), 32'd3, 32'd4, 1'b1); wait_done();
      issue(3'(MD_MSUB), 32'd5, 32'd5, 1'b1); wait_done();

      // Cancel at cycle 10
      issue(3'(MD_MULT), 32'd7, 32'd9, 1'b0);
      repeat (9) begin @(posedge clk); #1; end
      bus.i_cancel = 1'b1;
      @(posedge clk); #1;
      bus.i_cancel = 1'b0;
      check("cancel_busy", 64'(bus.o_busy), 64'd0);
      check("cancel_ready", 64'(bus.o_ready), 64'd1);
      check("cancel_hi", 64'(bus.o_hi), 64'(m_hi));
      check("cancel_lo", 64'(bus.o_lo), 64'(m_lo));
      expect_no_done("cancel_no_done", LAT + 4);

      // Direct HI write while busy aborts the op
      issue(3'(MD_DIVU), 32'd100, 32'd7, 1'b0);
      repeat (4) begin @(posedge clk); #1; end
      dwrite(1'b1, 1'b0, 32'h1234_5678);
      check("dwbusy_hi", 64'(bus.o_hi), 64'h1234_5678);
      check("dwbusy_lo", 64'(bus.o_lo), 64'(m_lo));
      check("dwbusy_busy", 64'(bus.o_busy), 64'd0);
      expect_no_done("dwbusy_no_done", LAT + 4);

      // Both write enables together
      dwrite(1'b1, 1'b1, 32'hA5A5_0F0F);
      check("dwboth_hi", 64'(bus.o_hi), 64'hA5A5_0F0F);
      check("dwboth_lo", 64'(bus.o_lo), 64'hA5A5_0F0F);

      // Random ops with assorted divisors, chained back-to-back
      for (int i = 0; i < 12; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         case (i % 4)
            0:       rb = $urandom;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'd0;
            default: rb = 32'hFFFF_FFFF;
         endcase
         if (i == 5) ra = 32'h8000_0000;
         issue(rop, ra, rb, 1'b1);
         wait_done();
      end
      @(posedge clk); #1;

      // i_valid together with a direct LO write while idle is not accepted
      bus.i_valid = 1'b1; bus.i_op = 3'(MD_MULT); bus.i_opr1 = 32'd3; bus.i_opr2 = 32'd3;
      bus.i_lo_we = 1'b1; bus.i_wdata = 32'h0000_CAFE;
      #1;
      check("vwe_ready", 64'(bus.o_ready), 64'd0);
      @(posedge clk); #1;
      bus.i_valid = 1'b0; bus.i_lo_we = 1'b0;
      m_lo = 32'h0000_CAFE;
      check("vwe_lo", 64'(bus.o_lo), 64'h0000_CAFE);
      check("vwe_busy", 64'(bus.o_busy), 64'd0);
      expect_no_done("vwe_no_done", 5);

      // Asynchronous reset mid-op
      issue(3'(MD_MULTU), 32'hDEAD_BEEF, 32'd17, 1'b0);
      repeat (5) begin @(posedge clk); #1; end
      #2;
      rst = 1'b1;
      #1;
      check("arst_hi", 64'(bus.o_hi), 64'd0);
      check("arst_lo", 64'(bus.o_lo), 64'd0);
      check("arst_busy", 64'(bus.o_busy), 64'd0);
      check("arst_done", 64'(bus.o_done), 64'd0);
      m_hi = '0; m_lo = '0;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Recovery after reset: accumulate onto cleared HI/LO
      issue(3'(MD_MADDU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done();
      issue(3'(MD_MSUBU), 32'd2, 32'd3, 1'b1); wait_done();

      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
